// File: rtl/alu_exec_seq.sv
// Execute-stage sequencer: IDLE->READ->EXEC->WB, one instruction per 4 cycles.
// Optional condition evaluation enabled by defining ALU_SEQ_COND_EN.
module alu_exec_seq #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_AW    = 4,
  parameter int unsigned UOP_W     = 5,
  parameter logic [3:0]  FLAGS_RST = 4'b0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [UOP_W-1:0]  in_uop,
  input  logic [3:0]        in_cond,
  input  logic              in_s,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_rn,
  input  logic [REG_AW-1:0] in_rm,
  input  logic              in_use_imm,
  input  logic [DATA_W-1:0] in_imm,
  output logic [REG_AW-1:0] rf_raddr_a,
  output logic [REG_AW-1:0] rf_raddr_b,
  input  logic [DATA_W-1:0] rf_rdata_a,
  input  logic [DATA_W-1:0] rf_rdata_b,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] alu_lhs,
  output logic [DATA_W-1:0] alu_rhs,
  output logic [UOP_W-1:0]  alu_uop,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [3:0]        alu_flags,
  output logic [3:0]        flags_q,
  output logic              done,
  output logic              skipped,
  output logic              illegal
);

  localparam logic [UOP_W-1:0] UOP_NOP = UOP_W'(0);
  localparam logic [UOP_W-1:0] UOP_CMP = UOP_W'(5);
  localparam logic [UOP_W-1:0] UOP_MAX = UOP_W'(8);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB
  } state_t;

  state_t              state;
  logic [UOP_W-1:0]    uop_q;
  logic                s_q;
  logic [REG_AW-1:0]   rd_q;
  logic                use_imm_q;
  logic [DATA_W-1:0]   imm_q;
  logic                pass_q;
  logic                legal_q;
  logic                pass_c;
  logic                legal_c;
  logic                exe_c;
  logic                wr_c;
  logic                flag_upd_c;

`ifdef ALU_SEQ_COND_EN
  logic [3:0] cond_q;

  // ARM condition evaluation against flags ordered [Z,C,N,V]
  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic z, cy, n, v;
    z  = f[3];
    cy = f[2];
    n  = f[1];
    v  = f[0];
    case (c)
      4'd0:    cond_eval = z;
      4'd1:    cond_eval = !z;
      4'd2:    cond_eval = cy;
      4'd3:    cond_eval = !cy;
      4'd4:    cond_eval = n;
      4'd5:    cond_eval = !n;
      4'd6:    cond_eval = v;
      4'd7:    cond_eval = !v;
      4'd8:    cond_eval = cy & !z;
      4'd9:    cond_eval = !cy | z;
      4'd10:   cond_eval = (n == v);
      4'd11:   cond_eval = (n != v);
      4'd12:   cond_eval = !z & (n == v);
      4'd13:   cond_eval = z | (n != v);
      4'd14:   cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  assign pass_c = cond_eval(cond_q, flags_q);
`else
  logic cond_unused;
  assign cond_unused = ^in_cond;
  assign pass_c      = 1'b1;
`endif

  assign legal_c    = (uop_q <= UOP_MAX);
  assign exe_c      = pass_q & legal_q;
  assign wr_c       = exe_c & (uop_q != UOP_NOP) & (uop_q != UOP_CMP);
  assign flag_upd_c = exe_c & (uop_q != UOP_NOP) & (s_q | (uop_q == UOP_CMP));

  // Operands are only presented while the regfile data is valid
  assign alu_lhs = (state == S_EXEC) ? rf_rdata_a : '0;
  assign alu_rhs = (state == S_EXEC) ? (use_imm_q ? imm_q : rf_rdata_b) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      in_ready   <= 1'b1;
      uop_q      <= '0;
      s_q        <= 1'b0;
      rd_q       <= '0;
      use_imm_q  <= 1'b0;
      imm_q      <= '0;
      pass_q     <= 1'b0;
      legal_q    <= 1'b0;
      rf_raddr_a <= '0;
      rf_raddr_b <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      alu_uop    <= '0;
      flags_q    <= FLAGS_RST;
      done       <= 1'b0;
      skipped    <= 1'b0;
      illegal    <= 1'b0;
`ifdef ALU_SEQ_COND_EN
      cond_q     <= 4'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          rf_we   <= 1'b0;
          done    <= 1'b0;
          skipped <= 1'b0;
          illegal <= 1'b0;
          if (in_valid && in_ready) begin
            uop_q      <= in_uop;
            s_q        <= in_s;
            rd_q       <= in_rd;
            use_imm_q  <= in_use_imm;
            imm_q      <= in_imm;
            rf_raddr_a <= in_rn;
            rf_raddr_b <= in_rm;
`ifdef ALU_SEQ_COND_EN
            cond_q     <= in_cond;
`endif
            in_ready   <= 1'b0;
            state      <= S_READ;
          end
        end
        // flags_q is stable until EXEC ends, so the decision can be taken here
        S_READ: begin
          pass_q  <= pass_c;
          legal_q <= legal_c;
          alu_uop <= (pass_c && legal_c) ? uop_q : '0;
          state   <= S_EXEC;
        end
        S_EXEC: begin
          alu_uop  <= '0;
          rf_wdata <= alu_out;
          rf_waddr <= rd_q;
          rf_we    <= wr_c;
          done     <= 1'b1;
          skipped  <= !pass_q & legal_q;
          illegal  <= !legal_q;
          if (flag_upd_c) flags_q <= alu_flags;
          state    <= S_WB;
        end
        S_WB: begin
          rf_we    <= 1'b0;
          done     <= 1'b0;
          skipped  <= 1'b0;
          illegal  <= 1'b0;
          in_ready <= 1'b1;
          state    <= S_IDLE;
        end
        default: begin
          in_ready <= 1'b1;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Bench for alu_exec_seq: behavioural regfile and ALU, directed table, back-to-back,
// mid-instruction reset and randomized instructions against a reference model.
module tb_alu_exec_seq;

`ifdef ALU_SEQ_COND_EN
  localparam bit COND_EN = 1'b1;
`else
  localparam bit COND_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_uop;
  logic [3:0]  in_cond;
  logic        in_s;
  logic [3:0]  in_rd, in_rn, in_rm;
  logic        in_use_imm;
  logic [31:0] in_imm;
  logic [3:0]  rf_raddr_a, rf_raddr_b;
  logic [31:0] rf_rdata_a, rf_rdata_b;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] alu_lhs, alu_rhs;
  logic [4:0]  alu_uop;
  logic [31:0] alu_out;
  logic [3:0]  alu_flags;
  logic [3:0]  flags_q;
  logic        done, skipped, illegal;

  alu_exec_seq dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_uop(in_uop), .in_cond(in_cond), .in_s(in_s),
    .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm),
    .in_use_imm(in_use_imm), .in_imm(in_imm),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_lhs(alu_lhs), .alu_rhs(alu_rhs), .alu_uop(alu_uop),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .flags_q(flags_q), .done(done), .skipped(skipped), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Synchronous-read register file, cleared by reset
  logic [31:0] rf [16];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
      rf_rdata_a <= '0;
      rf_rdata_b <= '0;
    end else begin
      if (rf_we) rf[rf_waddr] <= rf_wdata;
      rf_rdata_a <= rf[rf_raddr_a];
      rf_rdata_b <= rf[rf_raddr_b];
    end
  end

  // ALU behaviour: returns {Z,C,N,V,result}
  function automatic logic [35:0] alu_f(input logic [4:0] u, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] w;
    logic [31:0] r;
    logic c, v;
    c = 1'b0; v = 1'b0; r = '0;
    case (u)
      5'd1: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32];
                  v = (a[31] == b[31]) && (r[31] != a[31]); end
      5'd2, 5'd5: begin r = a - b; c = (a >= b); v = (a[31] != b[31]) && (r[31] != a[31]); end
      5'd3: r = a & b;
      5'd4: r = a ^ b;
      5'd6: r = a << b[4:0];
      5'd7: r = a >> b[4:0];
      5'd8: r = b;
      default: r = '0;
    endcase
    return {(r == 32'd0), c, r[31], v, r};
  endfunction

  always_comb {alu_flags, alu_out} = alu_f(alu_uop, alu_lhs, alu_rhs);

  typedef struct {
    logic [4:0]  uop;
    logic [3:0]  cond;
    logic        s;
    logic [3:0]  rd, rn, rm;
    logic        use_imm;
    logic [31:0] imm;
  } instr_t;

  typedef struct {
    logic [4:0]  uop;
    logic [31:0] lhs, rhs;
    logic        we;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic        skip, ill;
    logic [3:0]  flags;
  } exp_t;

  typedef struct {
    instr_t      i;
    logic        we;
    logic [31:0] wdata;
    logic        skip, ill;
    logic [3:0]  flags;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model_rf [16];
  logic [3:0]  model_flags;
  vec_t        tbl [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  // Condition truth: even codes test a predicate, odd codes its negation
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic z, cy, n, v, base;
    {z, cy, n, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'd15) return 1'b0;
    if (c < 4'd14 && c[0]) return !base;
    return base;
  endfunction

  function automatic exp_t model(input instr_t i);
    exp_t e;
    logic pass, legal, exe;
    logic [35:0] fr;
    e.lhs   = model_rf[i.rn];
    e.rhs   = i.use_imm ? i.imm : model_rf[i.rm];
    legal   = (i.uop <= 5'd8);
    pass    = COND_EN ? cond_ok(i.cond, model_flags) : 1'b1;
    exe     = pass && legal;
    fr      = alu_f(i.uop, e.lhs, e.rhs);
    e.uop   = exe ? i.uop : 5'd0;
    e.we    = exe && i.uop != 5'd0 && i.uop != 5'd5;
    e.waddr = i.rd;
    e.wdata = fr[31:0];
    e.skip  = !pass && legal;
    e.ill   = !legal;
    e.flags = (exe && i.uop != 5'd0 && (i.s || i.uop == 5'd5)) ? fr[35:32] : model_flags;
    return e;
  endfunction

  function automatic instr_t mk(input logic [4:0] uop, input logic [3:0] cond, input logic s,
                                input logic [3:0] rd, input logic [3:0] rn, input logic [3:0] rm,
                                input logic ui, input logic [31:0] imm);
    instr_t i;
    i.uop = uop; i.cond = cond; i.s = s; i.rd = rd; i.rn = rn; i.rm = rm;
    i.use_imm = ui; i.imm = imm;
    return i;
  endfunction

  task automatic tv(input instr_t i, input logic we, input logic [31:0] wd,
                    input logic sk, input logic il, input logic [3:0] fl);
    vec_t v;
    v.i = i; v.we = we; v.wdata = wd; v.skip = sk; v.ill = il; v.flags = fl;
    tbl.push_back(v);
  endtask

  task automatic drive(input instr_t i);
    in_uop = i.uop; in_cond = i.cond; in_s = i.s;
    in_rd = i.rd; in_rn = i.rn; in_rm = i.rm;
    in_use_imm = i.use_imm; in_imm = i.imm;
  endtask

  // Issue one instruction from an IDLE negedge and check each of its four cycles
  task automatic run(input instr_t i, input exp_t e, input string tag);
    int w;
    drive(i);
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 8) begin @(negedge clk); w++; end
    chk({tag, ".ready"}, 32'(in_ready), 32'd1);
    if (!in_ready) begin in_valid = 1'b0; return; end
    @(negedge clk);
    in_valid = 1'b0;
    drive(mk(5'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
             4'($urandom), 1'($urandom), $urandom));
    chk({tag, ".rd_busy"}, 32'(in_ready), 32'd0);
    chk({tag, ".rd_done"}, 32'(done), 32'd0);
    @(negedge clk);
    chk({tag, ".ex_uop"}, 32'(alu_uop), 32'(e.uop));
    chk({tag, ".ex_lhs"}, alu_lhs, e.lhs);
    chk({tag, ".ex_rhs"}, alu_rhs, e.rhs);
    chk({tag, ".ex_busy"}, 32'(in_ready), 32'd0);
    @(negedge clk);
    chk({tag, ".wb_done"}, 32'(done), 32'd1);
    chk({tag, ".wb_we"}, 32'(rf_we), 32'(e.we));
    if (e.we) begin
      chk({tag, ".wb_waddr"}, 32'(rf_waddr), 32'(e.waddr));
      chk({tag, ".wb_wdata"}, rf_wdata, e.wdata);
    end
    chk({tag, ".wb_skip"}, 32'(skipped), 32'(e.skip));
    chk({tag, ".wb_ill"}, 32'(illegal), 32'(e.ill));
    chk({tag, ".wb_busy"}, 32'(in_ready), 32'd0);
    @(negedge clk);
    chk({tag, ".id_ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".id_done"}, 32'(done), 32'd0);
    chk({tag, ".id_we"}, 32'(rf_we), 32'd0);
    chk({tag, ".flags"}, 32'(flags_q), 32'(e.flags));
    if (e.we) model_rf[e.waddr] = e.wdata;
    model_flags = e.flags;
  endtask

  // in_valid held high across two ADDs: accepts must land exactly 4 cycles apart
  task automatic back_to_back();
    int acc_k [$];
    int done_k [$];
    logic [31:0] wd [$];
    logic [3:0]  wa [$];
    drive(mk(5'd1, 4'd14, 1'b0, 4'd12, 4'd0, 4'd0, 1'b1, 32'h10));
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 1) drive(mk(5'd1, 4'd14, 1'b0, 4'd13, 4'd12, 4'd0, 1'b1, 32'h1));
      if (acc_k.size() == 2) in_valid = 1'b0;
      if (in_valid && in_ready) acc_k.push_back(k);
      if (k >= 1 && k <= 3) chk("b2b.busy", 32'(in_ready), 32'd0);
      if (done) begin done_k.push_back(k); wd.push_back(rf_wdata); wa.push_back(rf_waddr); end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("b2b.n_acc", 32'(acc_k.size()), 32'd2);
    chk("b2b.n_done", 32'(done_k.size()), 32'd2);
    if (acc_k.size() == 2) begin
      chk("b2b.acc0", 32'(acc_k[0]), 32'd0);
      chk("b2b.gap", 32'(acc_k[1] - acc_k[0]), 32'd4);
    end
    if (done_k.size() == 2) begin
      chk("b2b.done0", 32'(done_k[0]), 32'd3);
      chk("b2b.done1", 32'(done_k[1]), 32'd7);
      chk("b2b.wa0", 32'(wa[0]), 32'd12);
      chk("b2b.wd0", wd[0], 32'h10);
      chk("b2b.wa1", 32'(wa[1]), 32'd13);
      chk("b2b.wd1", wd[1], 32'h11);
    end
    model_rf[12] = 32'h10;
    model_rf[13] = 32'h11;
  endtask

  // Reset asserted while the instruction is in EXEC: it must vanish
  task automatic reset_in_exec();
    chk("rx.pre_flags", 32'(flags_q), 32'(model_flags));
    drive(mk(5'd1, 4'd14, 1'b1, 4'd14, 4'd0, 4'd0, 1'b1, 32'h55));
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("rx.ex_uop", 32'(alu_uop), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rx.ready", 32'(in_ready), 32'd1);
    chk("rx.we", 32'(rf_we), 32'd0);
    chk("rx.done", 32'(done), 32'd0);
    chk("rx.flags", 32'(flags_q), 32'd0);
    chk("rx.uop", 32'(alu_uop), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rx.no_done", 32'(done | rf_we), 32'd0);
    end
    for (int r = 0; r < 16; r++) model_rf[r] = '0;
    model_flags = 4'h0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    exp_t e;
    instr_t ri;
    rst = 1'b1;
    in_valid = 1'b0;
    drive(mk(5'd0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 32'd0));
    for (int r = 0; r < 16; r++) model_rf[r] = '0;
    model_flags = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst.ready", 32'(in_ready), 32'd1);
    chk("rst.we", 32'(rf_we), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.skip", 32'(skipped), 32'd0);
    chk("rst.ill", 32'(illegal), 32'd0);
    chk("rst.uop", 32'(alu_uop), 32'd0);
    chk("rst.lhs", alu_lhs, 32'd0);
    chk("rst.rhs", alu_rhs, 32'd0);
    chk("rst.raddr", 32'({rf_raddr_a, rf_raddr_b}), 32'd0);
    chk("rst.flags", 32'(flags_q), 32'd0);
    rst = 1'b0;

    // uop: 0 NOP 1 ADD 2 SUB 3 AND 4 XOR 5 CMP 6 LSL 7 LSR 8 MOV; cond 0 EQ 1 NE 14 AL 15 NV
    tv(mk(5'd8, 4'd14, 1'b0, 4'd2, 4'd0, 4'd0, 1'b1, 32'd5), 1'b1, 32'd5, 1'b0, 1'b0, 4'h0);
    tv(mk(5'd1, 4'd14, 1'b0, 4'd1, 4'd2, 4'd0, 1'b1, 32'd3), 1'b1, 32'd8, 1'b0, 1'b0, 4'h0);
    tv(mk(5'd8, 4'd14, 1'b0, 4'd1, 4'd0, 4'd0, 1'b1, 32'd1), 1'b1, 32'd1, 1'b0, 1'b0, 4'h0);
    tv(mk(5'd8, 4'd14, 1'b0, 4'd2, 4'd0, 4'd0, 1'b1, 32'd1), 1'b1, 32'd1, 1'b0, 1'b0, 4'h0);
    tv(mk(5'd2, 4'd14, 1'b1, 4'd3, 4'd1, 4'd2, 1'b0, 32'd0), 1'b1, 32'd0, 1'b0, 1'b0, 4'hC);
    tv(mk(5'd8, 4'd14, 1'b0, 4'd1, 4'd0, 4'd0, 1'b1, 32'h7FFFFFFF), 1'b1, 32'h7FFFFFFF, 1'b0, 1'b0, 4'hC);
    tv(mk(5'd8, 4'd14, 1'b0, 4'd2, 4'd0, 4'd0, 1'b1, 32'hFFFFFFFF), 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 4'hC);
    tv(mk(5'd5, 4'd14, 1'b0, 4'd5, 4'd1, 4'd2, 1'b0, 32'd0), 1'b0, 32'd0, 1'b0, 1'b0, 4'b0011);
    tv(mk(5'd5, 4'd14, 1'b0, 4'd5, 4'd1, 4'd1, 1'b0, 32'd0), 1'b0, 32'd0, 1'b0, 1'b0, 4'hC);
    tv(mk(5'd8, 4'd1, 1'b0, 4'd4, 4'd0, 4'd0, 1'b1, 32'hAA), !COND_EN, 32'hAA, COND_EN, 1'b0, 4'hC);
    tv(mk(5'd8, 4'd0, 1'b0, 4'd4, 4'd0, 4'd0, 1'b1, 32'h12345678), 1'b1, 32'h12345678, 1'b0, 1'b0, 4'hC);
    tv(mk(5'd9, 4'd14, 1'b1, 4'd5, 4'd1, 4'd2, 1'b0, 32'd0), 1'b0, 32'd0, 1'b0, 1'b1, 4'hC);
    tv(mk(5'd9, 4'd1, 1'b1, 4'd5, 4'd1, 4'd2, 1'b0, 32'd0), 1'b0, 32'd0, 1'b0, 1'b1, 4'hC);
    tv(mk(5'd0, 4'd14, 1'b1, 4'd5, 4'd1, 4'd2, 1'b0, 32'd0), 1'b0, 32'd0, 1'b0, 1'b0, 4'hC);
    tv(mk(5'd4, 4'd14, 1'b1, 4'd6, 4'd4, 4'd0, 1'b1, 32'h12345678), 1'b1, 32'd0, 1'b0, 1'b0, 4'h8);
    tv(mk(5'd1, 4'd15, 1'b0, 4'd7, 4'd4, 4'd0, 1'b1, 32'd1), !COND_EN, 32'h12345679, COND_EN, 1'b0, 4'h8);
    tv(mk(5'd6, 4'd14, 1'b1, 4'd8, 4'd4, 4'd0, 1'b1, 32'd4), 1'b1, 32'h23456780, 1'b0, 1'b0, 4'h0);
    tv(mk(5'd7, 4'd14, 1'b1, 4'd9, 4'd2, 4'd0, 1'b1, 32'd28), 1'b1, 32'hF, 1'b0, 1'b0, 4'h0);
    tv(mk(5'd1, 4'd14, 1'b1, 4'd10, 4'd2, 4'd0, 1'b1, 32'd1), 1'b1, 32'd0, 1'b0, 1'b0, 4'hC);
    tv(mk(5'd3, 4'd14, 1'b0, 4'd11, 4'd1, 4'd2, 1'b0, 32'd0), 1'b1, 32'h7FFFFFFF, 1'b0, 1'b0, 4'hC);

    for (int t = 0; t < tbl.size(); t++) begin
      e = model(tbl[t].i);
      e.we = tbl[t].we; e.wdata = tbl[t].wdata;
      e.skip = tbl[t].skip; e.ill = tbl[t].ill; e.flags = tbl[t].flags;
      run(tbl[t].i, e, $sformatf("tbl%0d", t));
    end

    back_to_back();
    reset_in_exec();

    for (int n = 0; n < 300; n++) begin
      ri = mk(5'($urandom_range(0, 11)), 4'($urandom_range(0, 15)), 1'($urandom),
              4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom),
              ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom);
      e = model(ri);
      run(ri, e, $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
